// File: rtl/ahb_slave_responder.sv
// ---------------------------------------------------------------------------
// ahb_slave_responder
//
// AHB-Lite completer: a word-addressed memory that answers NONSEQ/SEQ
// transfers from an AHB master. Each OKAY data phase can be stretched by a
// fixed number of wait states. Misaligned or out-of-range addresses get the
// standard two-cycle ERROR response. It is used as the reference AHB target
// in bridge benches and as a standalone slave model.
//
// Parameters
//   ADDR_W       HADDR width
//   DATA_W       HWDATA/HRDATA width (32-bit words only)
//   MEM_DEPTH    number of memory words; word index = HADDR[ADDR_W-1:2]
//                (must be at least 2)
//   WAIT_STATES  HREADY-low cycles inserted per OKAY data phase (0..7)
//
// Ports
//   clk      in   bus clock, all logic on the rising edge
//   rst      in   synchronous reset, active-high
//   HSELAHB  in   slave select
//   HADDR    in   address (address phase)
//   HTRANS   in   transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HWRITE   in   1 = write, 0 = read (address phase)
//   HWDATA   in   write data (data phase)
//   HREADY   out  1 = the current data phase completes this cycle
//   HRESP    out  0 = OKAY, 1 = ERROR
//   HRDATA   out  read data; valid in the completing cycle of an OKAY read
// ---------------------------------------------------------------------------
module ahb_slave_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSELAHB,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(MEM_DEPTH);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_waitCnt;
  logic                r_pending;
  logic [IDX_W-1:0]    r_idx;
  logic                r_write;
  logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

  state_t              w_nextState;
  logic [2:0]          w_nextCnt;
  logic                w_ready;
  logic                w_resp;
  logic                w_complete;
  logic                w_evaluate;
  logic                w_accept;
  logic                w_addrErr;
  logic                w_acceptOk;

  // HREADY only drops in the first ERROR cycle and in wait cycles that still
  // have a nonzero count. It is computed on its own so that the
  // address-phase acceptance below can depend on it without a loop through
  // the next-state logic.
  assign w_ready = !((r_state == ST_ERR1) ||
                     ((r_state == ST_WAIT) && (r_waitCnt != 3'd0)));

  // An address phase is taken only while the bus is ready. Alignment and
  // range are checked here, at acceptance, so the outcome is known before
  // the data phase starts.
  assign w_accept   = HSELAHB && HTRANS[1] && w_ready;
  assign w_addrErr  = (HADDR[1:0] != 2'b00) || (HADDR[ADDR_W-1:2] >= DEPTH_WORDS);
  assign w_acceptOk = w_accept && !w_addrErr;

  // Next-state and response logic. Any state whose current cycle has
  // HREADY=1 (IDLE, the last WAIT cycle, ERR2) also acts as the address
  // phase for the next transfer. That shared decision sits after the case
  // statement, controlled by w_evaluate.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_waitCnt;
    w_resp      = 1'b0;
    w_complete  = 1'b0;
    w_evaluate  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_complete = r_pending;
        w_evaluate = 1'b1;
      end
      ST_WAIT: begin
        if (r_waitCnt != 3'd0) begin
          w_nextCnt = r_waitCnt - 3'd1;
        end else begin
          w_complete = 1'b1;
          w_evaluate = 1'b1;
        end
      end
      ST_ERR1: begin
        w_resp      = 1'b1;
        w_nextState = ST_ERR2;
      end
      ST_ERR2: begin
        w_resp     = 1'b1;
        w_evaluate = 1'b1;
      end
      default: w_nextState = ST_IDLE;
    endcase
    if (w_evaluate) begin
      if (w_accept && w_addrErr) begin
        w_nextState = ST_ERR1;
      end else if (w_accept && !ZERO_WAIT) begin
        w_nextState = ST_WAIT;
        w_nextCnt   = WAIT_LOAD;
      end else begin
        w_nextState = ST_IDLE;
      end
    end
  end

  // State register plus the latched address-phase information. r_pending
  // marks a zero-wait data phase that completes while the FSM stays in
  // IDLE. Reset clears it, which drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= 3'd0;
      r_pending <= 1'b0;
      r_idx     <= '0;
      r_write   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextCnt;
      r_pending <= w_acceptOk && ZERO_WAIT;
      if (w_acceptOk) begin
        r_idx   <= HADDR[IDX_W+1:2];
        r_write <= HWRITE;
      end
    end
  end

  // The memory is never cleared. A write commits on the edge that ends its
  // OKAY data phase, so a read of the same word accepted on that edge
  // already sees the new value. Errored transfers never reach a completing
  // cycle, so they cannot write.
  always_ff @(posedge clk) begin
    if (!rst && w_complete && r_write) begin
      r_mem[r_idx] <= HWDATA;
    end
  end

  // Read data is driven only in the completing cycle of an OKAY read and is
  // held at zero at all other times.
  assign HREADY = w_ready;
  assign HRESP  = w_resp;
  assign HRDATA = (w_complete && !r_write) ? r_mem[r_idx] : '0;

endmodule
